// File: rtl/vga_pkg.sv
// Shared VGA constants and helpers for the framebuffer-to-VGA pixel pipeline.
//   H_ACTIVE / V_ACTIVE : visible screen size in pixels / lines
//   CNT_W               : width of the timing generator counters
//   DEF_COLOR_W         : default bits per colour channel
//   pix_w()             : pixel word width for a given channel width ({R,G,B})
package vga_pkg;
  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int CNT_W       = 10;
  localparam int DEF_COLOR_W = 4;

  // Width of one packed {R,G,B} pixel word.
  function automatic int pix_w(input int color_w);
    return 3 * color_w;
  endfunction
endpackage

// File: rtl/image_scaler_display_if.sv
// Framebuffer read bus between the pixel pipeline and the synchronous RAM.
//   image_addr  : read address (pipeline -> RAM)
//   image_rd_en : read strobe, only for in-window visible pixels (pipeline -> RAM)
//   image_data  : {R,G,B} read data, a fixed latency after image_addr (RAM -> pipeline)
// Modports: master = pixel pipeline, slave = RAM.
interface image_scaler_display_if #(
  parameter int ADDR_W = 17,
  parameter int PIX_W  = 12
);
  logic [ADDR_W-1:0] image_addr;
  logic              image_rd_en;
  logic [PIX_W-1:0]  image_data;

  modport master (output image_addr, output image_rd_en, input image_data);
  modport slave  (input image_addr, input image_rd_en, output image_data);
endinterface

// File: rtl/pipe_delay.sv
// Generic shift register with a per-instance reset value, used to align
// sync and flag signals with the RAM read latency.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : input word
//   dout       : din delayed by DEPTH cycles (DEPTH >= 1)
module pipe_delay #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift chain: stage 0 takes din, every later stage takes its predecessor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_r[i] <= RST_VAL;
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  assign dout = stage_r[DEPTH-1];
endmodule

// File: rtl/image_scaler_display.sv
// Framebuffer-to-VGA pixel pipeline. Maps screen counters onto a scaled,
// positioned image window, generates the framebuffer address incrementally
// (row base + column, no multiplier), hides the RAM latency and delays
// sync/visible so colour and sync leave together MEM_LATENCY+2 cycles later.
// Optional feature macro: COLOR_KEY_EN (adds color_key transparency input).
// Ports:
//   clk, rst_n          : pixel clock, asynchronous active-low reset
//   h_cnt, v_cnt        : screen column / line from the timing generator
//   visible             : active-video flag aligned to the counters
//   hsync_in, vsync_in  : negative syncs aligned to the counters
//   bg_color            : colour outside the window
//   color_key           : (COLOR_KEY_EN only) transparent pixel value
//   fb                  : framebuffer read bus (master side)
//   vga_r/g/b           : registered colour outputs
//   hsync_out/vsync_out : delayed syncs, aligned with vga_r/g/b
module image_scaler_display
  import vga_pkg::*;
#(
  parameter int IMG_W       = 320,
  parameter int IMG_H       = 240,
  parameter int SCALE_SHIFT = 1,
  parameter int X0          = 0,
  parameter int Y0          = 0,
  parameter int MEM_LATENCY = 1,
  parameter int COLOR_W     = DEF_COLOR_W,
  parameter int ADDR_W      = 17
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CNT_W-1:0]            h_cnt,
  input  logic [CNT_W-1:0]            v_cnt,
  input  logic                        visible,
  input  logic                        hsync_in,
  input  logic                        vsync_in,
  input  logic [pix_w(COLOR_W)-1:0]   bg_color,
`ifdef COLOR_KEY_EN
  input  logic [pix_w(COLOR_W)-1:0]   color_key,
`endif
  image_scaler_display_if.master      fb,
  output logic [COLOR_W-1:0]          vga_r,
  output logic [COLOR_W-1:0]          vga_g,
  output logic [COLOR_W-1:0]          vga_b,
  output logic                        hsync_out,
  output logic                        vsync_out
);
  localparam int PW    = pix_w(COLOR_W);
  // Two extra bits so window edges past the screen (X0 + scaled width > 640) still compare correctly.
  localparam int WIN_W = CNT_W + 2;
  localparam logic [WIN_W-1:0]  X_LO     = WIN_W'(X0);
  localparam logic [WIN_W-1:0]  X_HI     = WIN_W'(X0 + (IMG_W << SCALE_SHIFT));
  localparam logic [WIN_W-1:0]  Y_LO     = WIN_W'(Y0);
  localparam logic [WIN_W-1:0]  Y_HI     = WIN_W'(Y0 + (IMG_H << SCALE_SHIFT));
  localparam logic [WIN_W-1:0]  ROW_MASK = WIN_W'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ROW_MAX  = ADDR_W'((IMG_H - 1) * IMG_W);

  logic [WIN_W-1:0]  h_ext_s, v_ext_s, h_off_s, v_off_s;
  logic              h_in_s, v_in_s, in_win_s;
  logic [ADDR_W-1:0] col_s, row_base_nxt_s, row_base_r;
  logic [CNT_W-1:0]  v_prev_r;
  logic              in_win_d_s, vis_d_s;
  logic [PW-1:0]     bg_d_s, rgb_nxt_s;
  logic              hsync_d_s, vsync_d_s;

  assign h_ext_s = {2'b00, h_cnt};
  assign v_ext_s = {2'b00, v_cnt};

  // Window compare and column index; off-screen pixels are never inside the window.
  always_comb begin
    h_off_s  = h_ext_s - X_LO;
    v_off_s  = v_ext_s - Y_LO;
    h_in_s   = (h_ext_s >= X_LO) && (h_ext_s < X_HI) && (h_cnt < CNT_W'(H_ACTIVE));
    v_in_s   = (v_ext_s >= Y_LO) && (v_ext_s < Y_HI) && (v_cnt < CNT_W'(V_ACTIVE));
    in_win_s = visible && h_in_s && v_in_s;
    col_s    = ADDR_W'(h_off_s >> SCALE_SHIFT);
  end

  // Row base: cleared on the window's top line, stepped by IMG_W on the first
  // replicated line of each image row. Used combinationally so the first pixel
  // of a new line already sees the updated base. Clamped to keep addresses in range
  // after a mid-frame reset.
  always_comb begin
    row_base_nxt_s = row_base_r;
    if (v_cnt != v_prev_r) begin
      if (v_ext_s == Y_LO) begin
        row_base_nxt_s = {ADDR_W{1'b0}};
      end else if (v_in_s && ((v_off_s & ROW_MASK) == {WIN_W{1'b0}})) begin
        if (row_base_r >= ROW_MAX) begin
          row_base_nxt_s = ROW_MAX;
        end else begin
          row_base_nxt_s = row_base_r + ROW_STEP;
        end
      end else begin
        row_base_nxt_s = row_base_r;
      end
    end else begin
      row_base_nxt_s = row_base_r;
    end
  end

  // Stage 0: framebuffer address, read strobe and row tracking state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb.image_addr  <= {ADDR_W{1'b0}};
      fb.image_rd_en <= 1'b0;
      row_base_r     <= {ADDR_W{1'b0}};
      v_prev_r       <= {CNT_W{1'b0}};
    end else begin
      fb.image_addr  <= in_win_s ? (row_base_nxt_s + col_s) : {ADDR_W{1'b0}};
      fb.image_rd_en <= in_win_s;
      row_base_r     <= row_base_nxt_s;
      v_prev_r       <= v_cnt;
    end
  end

  // Flags and background travel through stage 0 plus MEM_LATENCY stages to meet image_data.
  pipe_delay #(
    .WIDTH   (PW + 2),
    .DEPTH   (MEM_LATENCY + 1),
    .RST_VAL ({(PW + 2){1'b0}})
  ) u_ctrl_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({in_win_s, visible, bg_color}),
    .dout  ({in_win_d_s, vis_d_s, bg_d_s})
  );

  // Syncs reset to the inactive (high) level of negative sync.
  pipe_delay #(
    .WIDTH   (2),
    .DEPTH   (MEM_LATENCY + 1),
    .RST_VAL (2'b11)
  ) u_sync_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({hsync_in, vsync_in}),
    .dout  ({hsync_d_s, vsync_d_s})
  );

  // Output colour mux: image inside the window, background elsewhere in active video, black in blanking.
  always_comb begin
    rgb_nxt_s = {PW{1'b0}};
    if (vis_d_s && in_win_d_s) begin
`ifdef COLOR_KEY_EN
      if (fb.image_data == color_key) begin
        rgb_nxt_s = bg_d_s;
      end else begin
        rgb_nxt_s = fb.image_data;
      end
`else
      rgb_nxt_s = fb.image_data;
`endif
    end else if (vis_d_s) begin
      rgb_nxt_s = bg_d_s;
    end else begin
      rgb_nxt_s = {PW{1'b0}};
    end
  end

  // Output stage: registered colour and syncs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r     <= {COLOR_W{1'b0}};
      vga_g     <= {COLOR_W{1'b0}};
      vga_b     <= {COLOR_W{1'b0}};
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      {vga_r, vga_g, vga_b} <= rgb_nxt_s;
      hsync_out             <= hsync_d_s;
      vsync_out             <= vsync_d_s;
    end
  end
endmodule

// File: tb/tb_image_scaler_display.sv
// Scoreboard bench for image_scaler_display. Three instances share one
// stimulus stream: A = defaults, B = window at (100,50), C = MEM_LATENCY 3.
// Each RAM model returns data = addr[11:0] after its latency.
module tb_image_scaler_display;
  localparam int K_ADDR_A = 0, K_RDEN_A = 1, K_RGB_A = 2, K_HS_A = 3, K_VS_A = 4;
  localparam int K_ADDR_B = 5, K_RDEN_B = 6, K_RGB_B = 7, K_RGB_C = 8, K_HS_C = 9;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
  } chk_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] h_cnt, v_cnt;
  logic       visible, hsync_in, vsync_in;
  logic [11:0] bg_color;
`ifdef COLOR_KEY_EN
  logic [11:0] color_key;
`endif
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
  logic       hs_a, vs_a, hs_b, vs_b, hs_c, vs_c;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   max_addr = 0;
  chk_t sb_q[$];

  image_scaler_display_if #(.ADDR_W(17), .PIX_W(12)) fb_a ();
  image_scaler_display_if #(.ADDR_W(17), .PIX_W(12)) fb_b ();
  image_scaler_display_if #(.ADDR_W(17), .PIX_W(12)) fb_c ();

  logic [11:0] ram_a_q = 12'h000;
  logic [11:0] ram_b_q = 12'h000;
  logic [11:0] ram_c_q [3] = '{12'h000, 12'h000, 12'h000};

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural synchronous RAMs.
  always @(posedge clk) begin
    ram_a_q    <= fb_a.image_addr[11:0];
    ram_b_q    <= fb_b.image_addr[11:0];
    ram_c_q[0] <= fb_c.image_addr[11:0];
    ram_c_q[1] <= ram_c_q[0];
    ram_c_q[2] <= ram_c_q[1];
  end
  assign fb_a.image_data = ram_a_q;
  assign fb_b.image_data = ram_b_q;
  assign fb_c.image_data = ram_c_q[2];

  image_scaler_display dut_a (
`ifdef COLOR_KEY_EN
    .color_key(color_key),
`endif
    .clk(clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt), .visible(visible),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .bg_color(bg_color), .fb(fb_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .hsync_out(hs_a), .vsync_out(vs_a));

  image_scaler_display #(.X0(100), .Y0(50)) dut_b (
`ifdef COLOR_KEY_EN
    .color_key(color_key),
`endif
    .clk(clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt), .visible(visible),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .bg_color(bg_color), .fb(fb_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .hsync_out(hs_b), .vsync_out(vs_b));

  image_scaler_display #(.MEM_LATENCY(3)) dut_c (
`ifdef COLOR_KEY_EN
    .color_key(color_key),
`endif
    .clk(clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt), .visible(visible),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .bg_color(bg_color), .fb(fb_c),
    .vga_r(r_c), .vga_g(g_c), .vga_b(b_c), .hsync_out(hs_c), .vsync_out(vs_c));

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      K_ADDR_A: return 32'(fb_a.image_addr);
      K_RDEN_A: return 32'(fb_a.image_rd_en);
      K_RGB_A:  return 32'({r_a, g_a, b_a});
      K_HS_A:   return 32'(hs_a);
      K_VS_A:   return 32'(vs_a);
      K_ADDR_B: return 32'(fb_b.image_addr);
      K_RDEN_B: return 32'(fb_b.image_rd_en);
      K_RGB_B:  return 32'({r_b, g_b, b_b});
      K_RGB_C:  return 32'({r_c, g_c, b_c});
      K_HS_C:   return 32'(hs_c);
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic string kname(input int kind);
    case (kind)
      K_ADDR_A: return "addr_a";
      K_RDEN_A: return "rd_en_a";
      K_RGB_A:  return "rgb_a";
      K_HS_A:   return "hsync_a";
      K_VS_A:   return "vsync_a";
      K_ADDR_B: return "addr_b";
      K_RDEN_B: return "rd_en_b";
      K_RGB_B:  return "rgb_b";
      K_RGB_C:  return "rgb_c";
      K_HS_C:   return "hsync_c";
      default:  return "unknown";
    endcase
  endfunction

  // Monitor: compare every scoreboard entry that falls due in this cycle.
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due == cyc) begin
        logic [31:0] act;
        act = actual(sb_q[i].kind);
        n_checks++;
        if (act !== sb_q[i].exp) begin
          n_errors++;
          $display("FAIL %s cyc=%0d got=%0h exp=%0h", kname(sb_q[i].kind), cyc, act, sb_q[i].exp);
        end
        sb_q.delete(i);
      end
    end
    if (rst_n === 1'b1) begin
      if (int'(fb_a.image_addr) > max_addr) max_addr = int'(fb_a.image_addr);
      if (int'(fb_b.image_addr) > max_addr) max_addr = int'(fb_b.image_addr);
      if (int'(fb_c.image_addr) > max_addr) max_addr = int'(fb_c.image_addr);
    end
  end

  task automatic expect_at(input int lat, input int kind, input logic [31:0] exp);
    chk_t e;
    e.due  = cyc + lat;
    e.kind = kind;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic step(input int h, input int v, input logic vis);
    @(posedge clk);
    #1;
    h_cnt   = 10'(h);
    v_cnt   = 10'(v);
    visible = vis;
  endtask

  initial begin
    rst_n = 1'b0; h_cnt = 10'd0; v_cnt = 10'd0; visible = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; bg_color = 12'h0A5;
`ifdef COLOR_KEY_EN
    color_key = 12'h005;
`endif
    // Reset state.
    step(0, 0, 0);
    expect_at(0, K_ADDR_A, 32'd0); expect_at(0, K_RDEN_A, 32'd0); expect_at(0, K_RGB_A, 32'd0);
    expect_at(0, K_HS_A, 32'd1);   expect_at(0, K_VS_A, 32'd1);
    step(0, 0, 0);
    #1 rst_n = 1'b1;
    step(0, 0, 0);

    // Replicated pixels on line 0, latency 1 cycle to address, 3 to colour.
    step(0, 0, 1);
    expect_at(1, K_ADDR_A, 32'd0); expect_at(1, K_RDEN_A, 32'd1); expect_at(3, K_RGB_A, 32'h000);
    expect_at(1, K_RDEN_B, 32'd0); expect_at(3, K_RGB_B, 32'h0A5);
    step(1, 0, 1);  expect_at(1, K_ADDR_A, 32'd0);
    step(2, 0, 1);  expect_at(1, K_ADDR_A, 32'd1);  expect_at(3, K_RGB_A, 32'h001);
    step(3, 0, 1);  expect_at(1, K_ADDR_A, 32'd1);
    step(20, 0, 1); expect_at(1, K_ADDR_A, 32'd10); expect_at(3, K_RGB_A, 32'h00A);
    expect_at(5, K_RGB_C, 32'h00A);
    step(8, 0, 1);  expect_at(3, K_RGB_A, 32'h004);
    step(10, 0, 1); expect_at(1, K_ADDR_A, 32'd5);
`ifdef COLOR_KEY_EN
    expect_at(3, K_RGB_A, 32'h0A5);
`else
    expect_at(3, K_RGB_A, 32'h005);
`endif
    step(12, 0, 1); expect_at(3, K_RGB_A, 32'h006);
    step(20, 0, 0); expect_at(1, K_ADDR_A, 32'd0); expect_at(1, K_RDEN_A, 32'd0);
    expect_at(3, K_RGB_A, 32'h000);

    // Row stepping through the frame down to the last pixel.
    step(0, 1, 1);
    step(0, 2, 1);  expect_at(1, K_ADDR_A, 32'd320); expect_at(3, K_RGB_A, 32'h140);
    step(5, 3, 1);  expect_at(1, K_ADDR_A, 32'd322);
    for (int v = 4; v < 480; v++) begin
      step(639, v, 1);
      if (v >= 478) expect_at(1, K_ADDR_A, 32'd76799);
    end
    expect_at(3, K_RGB_A, 32'hBFF);
    for (int v = 480; v < 525; v++) step(0, v, 0);

    // Offset window with red background.
    step(0, 0, 0);
    bg_color = 12'hF00;
    step(99, 49, 1);
    step(99, 50, 1);  expect_at(3, K_RGB_B, 32'hF00);
    step(100, 50, 1); expect_at(1, K_ADDR_B, 32'd0); expect_at(1, K_RDEN_B, 32'd1);
    expect_at(3, K_RGB_B, 32'h000);
    step(102, 50, 1); expect_at(1, K_ADDR_B, 32'd1);   expect_at(3, K_RGB_B, 32'h001);
    step(639, 50, 1); expect_at(1, K_ADDR_B, 32'd269); expect_at(3, K_RGB_B, 32'h10D);
    step(740, 50, 1); expect_at(1, K_RDEN_B, 32'd0);   expect_at(3, K_RGB_B, 32'hF00);
    step(200, 50, 0); expect_at(3, K_RGB_B, 32'h000);
    step(0, 51, 0);
    bg_color = 12'h0A5;

    // Sync delay: 3 cycles by default, 5 with MEM_LATENCY 3.
    step(655, 490, 0);
    step(656, 490, 0);
    hsync_in = 1'b0;
    expect_at(2, K_HS_A, 32'd1); expect_at(3, K_HS_A, 32'd0);
    expect_at(4, K_HS_C, 32'd1); expect_at(5, K_HS_C, 32'd0);
    for (int h = 657; h < 661; h++) step(h, 490, 0);
    step(661, 490, 0);
    hsync_in = 1'b1;
    expect_at(2, K_HS_A, 32'd0); expect_at(3, K_HS_A, 32'd1);
    step(0, 491, 0);
    vsync_in = 1'b0;
    expect_at(2, K_VS_A, 32'd1); expect_at(3, K_VS_A, 32'd0);
    step(1, 491, 0);
    step(2, 491, 0);
    vsync_in = 1'b1;

    // Mid-frame reset at line 200 with hsync low in the pipeline.
    step(0, 199, 1);
    hsync_in = 1'b0;
    step(10, 200, 1);
    step(11, 200, 1);
    step(12, 200, 1);
    #5 rst_n = 1'b0;
    expect_at(0, K_ADDR_A, 32'd0); expect_at(0, K_RDEN_A, 32'd0); expect_at(0, K_RGB_A, 32'd0);
    expect_at(0, K_HS_A, 32'd1);   expect_at(0, K_VS_A, 32'd1);   expect_at(0, K_HS_C, 32'd1);
    step(13, 200, 1);
    step(14, 200, 1);
    hsync_in = 1'b1;
    #5 rst_n = 1'b1;
    for (int v = 201; v < 525; v++) step(0, v, v < 480);

    // Frame 2 must follow the golden mapping (v>>1)*320 + (h>>1).
    for (int v = 0; v < 480; v++) begin
      int h;
      h = (v * 37) % 640;
      step(h, v, 1);
      expect_at(1, K_ADDR_A, 32'((v / 2) * 320 + h / 2));
    end
    for (int i = 0; i < 8; i++) step(0, 480, 0);

    n_checks++;
    if (max_addr > 76799) begin
      n_errors++;
      $display("FAIL max_addr got=%0d limit=76799", max_addr);
    end
    while (sb_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s missed due=%0d exp=%0h", kname(sb_q[0].kind), sb_q[0].due, sb_q[0].exp);
      void'(sb_q.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
